// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the bus arbiter: state encoding, owner index width,
// and the wrapping increment used for the round-robin pointer.
package bus_arbiter_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int OWNER_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx,
                                                    input int n);
        if (int'(idx) >= n - 1) return '0;
        return idx + OWNER_W'(1);
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational winner pick: rotate requests by ptr, take the lowest set bit,
// rotate the index back. ptr must be below N.
module bus_arbiter_rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [N-1:0]       win_oh,
    output logic [OWNER_W-1:0] win_idx,
    output logic               win_valid
);

    logic [N-1:0]       rot;
    logic [OWNER_W-1:0] rot_idx;
    logic [OWNER_W:0]   sum;

    always_comb begin
        rot     = N'({req, req} >> ptr);
        rot_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) rot_idx = OWNER_W'(i);
        end
        sum = {1'b0, rot_idx} + {1'b0, ptr};
        if (sum >= (OWNER_W + 1)'(N)) sum = sum - (OWNER_W + 1)'(N);
        win_idx   = sum[OWNER_W-1:0];
        win_valid = |req;
        win_oh    = '0;
        for (int i = 0; i < N; i++) begin
            win_oh[i] = win_valid && (win_idx == OWNER_W'(i));
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: one-hot registered grant, tenure tracking via b_bus_utilizing,
// timeout revocation of idle grants and a fixed grant-low turnaround between tenures.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int TIMEOUT_LEN = 6,
    parameter int TURNAROUND  = 2,
    parameter int RR_MODE     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] b_request,
    input  logic                 b_bus_utilizing,
    output logic [N_MASTERS-1:0] b_grant,
    output logic                 arb_busy,
    output logic [2:0]           arb_owner,
    output logic                 arb_timeout,
    output logic [1:0]           arb_state
);

    localparam int TRN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam logic [TRN_W-1:0]       TRN_LAST = TRN_W'(TURNAROUND - 1);
    localparam logic [TRN_W-1:0]       TRN_ONE  = TRN_W'(1);
    localparam logic [TIMEOUT_LEN-1:0] TCNT_MAX = '1;
    localparam logic [TIMEOUT_LEN-1:0] TCNT_ONE = TIMEOUT_LEN'(1);

    arb_state_e             state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;
    logic [OWNER_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TIMEOUT_LEN-1:0] tcnt_q, tcnt_d;
    logic [TRN_W-1:0]       trn_q, trn_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;

    logic [OWNER_W-1:0]     pick_ptr;
    logic [N_MASTERS-1:0]   win_oh;
    logic [OWNER_W-1:0]     win_idx;
    logic                   win_valid;
    logic                   owner_req;

    assign pick_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

    bus_arbiter_rr_picker #(.N(N_MASTERS)) u_picker (
        .req       (b_request),
        .ptr       (pick_ptr),
        .win_oh    (win_oh),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // Request/grant handshake: a master holds b_request high for as long as it wants
    // the bus; the grant stays with it until it lowers the request outside a transfer,
    // or the grant sits unused long enough to be revoked.
    // The grant vector is only non-zero in GRANT/BUSY, so masking selects the owner.
    assign owner_req = |(b_request & grant_q);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        tcnt_d    = tcnt_q;
        trn_d     = trn_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d  = win_oh;
                    owner_d  = win_idx;
                    tcnt_d   = '0;
                    rr_ptr_d = wrap_inc(win_idx, N_MASTERS);
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    grant_d = '0;
                    trn_d   = '0;
                    state_d = ST_RELEASE;
                end else if (b_bus_utilizing) begin
                    tcnt_d  = '0;
                    state_d = ST_BUSY;
                end else begin
                    tcnt_d = tcnt_q + TCNT_ONE;
                    if (tcnt_d == TCNT_MAX) begin
                        grant_d   = '0;
                        trn_d     = '0;
                        timeout_d = 1'b1;
                        state_d   = ST_RELEASE;
                    end
                end
            end
            ST_BUSY: begin
                if (!b_bus_utilizing) begin
                    if (owner_req) begin
                        tcnt_d  = '0;
                        state_d = ST_GRANT;
                    end else begin
                        grant_d = '0;
                        trn_d   = '0;
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                if (trn_q == TRN_LAST) state_d = ST_IDLE;
                else                   trn_d   = trn_q + TRN_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            tcnt_q    <= '0;
            trn_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            tcnt_q    <= tcnt_d;
            trn_q     <= trn_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign b_grant     = grant_q;
    assign arb_busy    = busy_q;
    assign arb_owner   = owner_q;
    assign arb_timeout = timeout_q;
    assign arb_state   = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: round-robin and fixed-priority instances checked every cycle
// against a tenure-level reference model, plus directed boundary checks.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int TL = 6;
    localparam int TA = 2;
    localparam int W  = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0, req_b = '0;
    logic       util_a = 1'b0, util_b = 1'b0;
    logic [3:0] grant_a, grant_b;
    logic       busy_a, busy_b, tmo_a, tmo_b;
    logic [2:0] owner_a, owner_b;
    logic [1:0] state_a, state_b;

    bus_arbiter #(.N_MASTERS(N), .TIMEOUT_LEN(TL), .TURNAROUND(TA), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .b_request(req_a), .b_bus_utilizing(util_a),
        .b_grant(grant_a), .arb_busy(busy_a), .arb_owner(owner_a),
        .arb_timeout(tmo_a), .arb_state(state_a)
    );

    bus_arbiter #(.N_MASTERS(N), .TIMEOUT_LEN(TL), .TURNAROUND(TA), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .b_request(req_b), .b_bus_utilizing(util_b),
        .b_grant(grant_b), .arb_busy(busy_b), .arb_owner(owner_b),
        .arb_timeout(tmo_b), .arb_state(state_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // reference model: one tenure record per instance (0 = round-robin, 1 = fixed)
    int m_owner[2];
    int m_last[2];
    int m_idle[2];
    int m_gap[2];
    int m_ptr[2];
    bit m_frame[2];
    bit m_tmo[2];
    bit m_new[2];

    task automatic model_reset(input int i);
        m_owner[i] = -1; m_last[i] = 0; m_idle[i] = 0; m_gap[i] = 0;
        m_ptr[i] = 0; m_frame[i] = 0; m_tmo[i] = 0; m_new[i] = 0;
    endtask

    task automatic model_release(input int i);
        m_owner[i] = -1;
        m_frame[i] = 0;
        m_gap[i]   = TA;
    endtask

    function automatic logic [W-1:0] model_vec(input int i);
        logic [3:0] g;
        logic       b;
        g = (m_owner[i] >= 0) ? 4'(1 << m_owner[i]) : 4'b0000;
        b = (m_owner[i] >= 0) || (m_gap[i] > 0);
        return {g, b, 3'(m_last[i]), m_tmo[i]};
    endfunction

    task automatic model_step(input int i, input logic [3:0] r, input logic u, input bit rr);
        int  start;
        int  cand;
        bit  found;
        m_tmo[i] = 0;
        m_new[i] = 0;
        if (rst) begin
            model_reset(i);
        end else if (m_owner[i] >= 0) begin
            if (!m_frame[i]) begin
                if (!r[m_owner[i]]) model_release(i);
                else if (u) m_frame[i] = 1;
                else begin
                    m_idle[i]++;
                    if (m_idle[i] == (1 << TL) - 1) begin
                        model_release(i);
                        m_tmo[i] = 1;
                    end
                end
            end else if (!u) begin
                if (r[m_owner[i]]) begin
                    m_frame[i] = 0;
                    m_idle[i]  = 0;
                end else model_release(i);
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
        end else begin
            start = rr ? m_ptr[i] : 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                cand = (start + k) % N;
                if (!found && r[cand]) begin
                    found      = 1;
                    m_owner[i] = cand;
                    m_last[i]  = cand;
                    m_idle[i]  = 0;
                    m_frame[i] = 0;
                    m_ptr[i]   = (cand + 1) % N;
                    m_new[i]   = 1;
                end
            end
        end
        exp_q.push_back(model_vec(i));
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic drive(input logic [3:0] r, input logic u);
        req_a = r; req_b = r; util_a = u; util_b = u;
    endtask

    task automatic tick();
        model_step(0, req_a, util_a, 1'b1);
        model_step(1, req_b, util_b, 1'b0);
        @(posedge clk);
        #1;
        check("cycle_rr", {grant_a, busy_a, owner_a, tmo_a}, exp_q.pop_front());
        check("cycle_fp", {grant_b, busy_b, owner_b, tmo_b}, exp_q.pop_front());
        check("onehot", {8'b0, $onehot0(grant_a) && $onehot0(grant_b)}, 9'd1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("async_rst_rr", {grant_a, busy_a, owner_a, tmo_a}, '0);
        check("async_rst_fp", {grant_b, busy_b, owner_b, tmo_b}, '0);
        tick();
        rst = 1'b0;
    endtask

    int   na, nb;
    int   ph[2];
    int   exp_rr[5];
    logic [3:0] rnd_req;
    logic       rnd_util;

    initial begin
        #200000;
        $display("FAIL watchdog expired before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset(0);
        model_reset(1);
        drive(4'b0000, 1'b0);
        tick();
        check("reset_state", {6'b0, state_a}, 9'd0);
        rst = 1'b0;

        // 1: single request, one-clock latency
        drive(4'b0100, 1'b0);
        tick();
        check("t1_grant", grant_a, 9'h004);
        check("t1_busy", busy_a, 9'd1);
        check("t1_owner", owner_a, 9'd2);
        tick();
        drive(4'b0000, 1'b0);
        repeat (4) tick();

        // 2: two frames in one tenure, then release
        drive(4'b0010, 1'b0); tick();
        drive(4'b0010, 1'b1); tick(); tick();
        drive(4'b0010, 1'b0); tick();
        drive(4'b0010, 1'b1); tick(); tick();
        drive(4'b0010, 1'b0); tick();
        check("t2_held", grant_a, 9'h002);
        tick();
        drive(4'b0000, 1'b0); tick();
        check("t2_drop", grant_a, 9'h000);
        tick();
        check("t2_gap_busy", busy_a, 9'd1);
        tick();
        check("t2_idle", busy_a, 9'd0);

        // 3: all masters requesting, each gives up after one frame
        apply_reset();
        exp_rr = '{0, 1, 2, 3, 0};
        na = 0; nb = 0; ph[0] = 0; ph[1] = 0;
        req_a = 4'b1111; req_b = 4'b1111; util_a = 1'b0; util_b = 1'b0;
        for (int cyc = 0; cyc < 80 && (na < 5 || nb < 5); cyc++) begin
            if (m_owner[0] >= 0) begin
                if (ph[0] < 2) util_a = 1'b1;
                else begin util_a = 1'b0; req_a[m_owner[0]] = 1'b0; end
                ph[0]++;
            end else begin
                ph[0] = 0; util_a = 1'b0; req_a = 4'b1111;
            end
            if (m_owner[1] >= 0) begin
                if (ph[1] < 2) util_b = 1'b1;
                else begin util_b = 1'b0; req_b[m_owner[1]] = 1'b0; end
                ph[1]++;
            end else begin
                ph[1] = 0; util_b = 1'b0; req_b = 4'b1111;
            end
            tick();
            if (m_new[0]) begin
                if (na < 5) check("t3_rr_order", owner_a, 9'(exp_rr[na]));
                na++;
            end
            if (m_new[1]) begin
                if (nb < 5) check("t3_fp_order", owner_b, 9'd0);
                nb++;
            end
        end
        check("t3_rr_count", {8'b0, na >= 5}, 9'd1);
        check("t3_fp_count", {8'b0, nb >= 5}, 9'd1);

        // 4: unused grant is revoked by timeout
        apply_reset();
        drive(4'b1000, 1'b0);
        tick();
        check("t4_grant", grant_a, 9'h008);
        for (int k = 1; k <= 63; k++) begin
            tick();
            if (k == 62) begin
                check("t4_hold62", grant_a, 9'h008);
                check("t4_no_tmo62", tmo_a, 9'd0);
            end
            if (k == 63) begin
                check("t4_revoke", grant_a, 9'h000);
                check("t4_tmo_pulse", tmo_a, 9'd1);
            end
        end
        drive(4'b1001, 1'b0);
        tick();
        check("t4_tmo_end", tmo_a, 9'd0);
        tick(); tick();
        check("t4_next_rr", grant_a, 9'h001);
        check("t4_next_fp", grant_b, 9'h001);

        // 5: asynchronous reset mid-transfer
        apply_reset();
        drive(4'b0010, 1'b0); tick();
        drive(4'b0010, 1'b1); tick();
        check("t5_busy_state", {6'b0, state_a}, 9'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_grant", grant_a, 9'h000);
        check("t5_async_outs", {busy_a, owner_a, tmo_a}, 9'd0);
        model_reset(0);
        model_reset(1);
        drive(4'b0010, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("t5_regrant", grant_a, 9'h002);
        check("t5_owner", owner_a, 9'd1);

        // 6: request drop wins over utilizing rise
        apply_reset();
        drive(4'b0001, 1'b0); tick();
        drive(4'b0000, 1'b1); tick();
        check("t6_drop", grant_a, 9'h000);
        check("t6_release", {6'b0, state_a}, 9'd3);
        drive(4'b0000, 1'b0);
        tick(); tick();
        check("t6_idle", busy_a, 9'd0);

        // randomized traffic, both arbitration modes on the same inputs
        apply_reset();
        rnd_req  = '0;
        rnd_util = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) rnd_util = ~rnd_util;
            drive(rnd_req, rnd_util);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
